// File: rtl/testeio_mem_port_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the memory port.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface testeio_mem_port_arbiter_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    logic [ADDR_W-1:0] m0_address,       m1_address;
    logic              m0_read,          m1_read;
    logic              m0_write,         m1_write;
    logic [DATA_W-1:0] m0_writedata,     m1_writedata;
    logic [BE_W-1:0]   m0_byteenable,    m1_byteenable;
    logic              m0_lock,          m1_lock;
    logic              m0_waitrequest,   m1_waitrequest;
    logic [DATA_W-1:0] m0_readdata,      m1_readdata;
    logic              m0_readdatavalid, m1_readdatavalid;

    logic [ADDR_W-1:0] mem_address;
    logic [BE_W-1:0]   mem_byteenable;
    logic              mem_chipselect;
    logic              mem_write;
    logic [DATA_W-1:0] mem_writedata;
    logic [DATA_W-1:0] mem_readdata;

    modport slave (
        input  m0_address, m1_address, m0_read, m1_read, m0_write, m1_write,
        input  m0_writedata, m1_writedata, m0_byteenable, m1_byteenable,
        input  m0_lock, m1_lock, mem_readdata,
        output m0_waitrequest, m1_waitrequest, m0_readdata, m1_readdata,
        output m0_readdatavalid, m1_readdatavalid,
        output mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata
    );

    modport master (
        output m0_address, m1_address, m0_read, m1_read, m0_write, m1_write,
        output m0_writedata, m1_writedata, m0_byteenable, m1_byteenable,
        output m0_lock, m1_lock, mem_readdata,
        input  m0_waitrequest, m1_waitrequest, m0_readdata, m1_readdata,
        input  m0_readdatavalid, m1_readdatavalid,
        input  mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata
    );
endinterface

// File: rtl/testeio_mem_port_arbiter.sv
// Two-master arbiter for one memory port: round-robin grant, lock ownership, read data
// steered back to the issuer. Define MEMARB_READ_REG_EN for a registered read return (latency 2).
module testeio_mem_port_arbiter #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       reset_n,
    testeio_mem_port_arbiter_if.slave  bus
);
    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              last_q, last_d;      // 1 = master 1 was served most recently
    logic              req0_s, req1_s, gnt0_s, gnt1_s, gnt_s, wr_s;
    logic [ADDR_W-1:0] addr_q, addr_s;
    logic [BE_W-1:0]   be_q, be_s;
    logic [DATA_W-1:0] wdata_q, wdata_s;
    logic              rd_issue_q, rd_own_q;
    logic              rdv0_s, rdv1_s;
    logic [DATA_W-1:0] rd0_q, rd1_q;

    assign req0_s = bus.m0_read | bus.m0_write;
    assign req1_s = bus.m1_read | bus.m1_write;
    assign gnt_s  = gnt0_s | gnt1_s;

    // Grant selection and ownership next state
    always_comb begin
        gnt0_s  = 1'b0;
        gnt1_s  = 1'b0;
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                gnt0_s = req0_s & (~req1_s | last_q);
                gnt1_s = req1_s & (~req0_s | ~last_q);
            end
            ST_OWN0: gnt0_s = req0_s;
            ST_OWN1: gnt1_s = req1_s;
            default: begin
                gnt0_s = 1'b0;
                gnt1_s = 1'b0;
            end
        endcase
        if (gnt0_s) begin
            last_d  = 1'b0;
            state_d = bus.m0_lock ? ST_OWN0 : ST_IDLE;
        end else if (gnt1_s) begin
            last_d  = 1'b1;
            state_d = bus.m1_lock ? ST_OWN1 : ST_IDLE;
        end else begin
            last_d  = last_q;
            // an unreachable encoding falls back to IDLE rather than locking everyone out
            state_d = (state_q == ST_OWN0 || state_q == ST_OWN1) ? state_q : ST_IDLE;
        end
    end

    // Memory-side mux; address and data hold their last value when nobody is granted
    always_comb begin
        addr_s  = addr_q;
        be_s    = be_q;
        wdata_s = wdata_q;
        wr_s    = 1'b0;
        if (gnt0_s) begin
            addr_s  = bus.m0_address;
            be_s    = bus.m0_byteenable;
            wdata_s = bus.m0_writedata;
            wr_s    = bus.m0_write;
        end else if (gnt1_s) begin
            addr_s  = bus.m1_address;
            be_s    = bus.m1_byteenable;
            wdata_s = bus.m1_writedata;
            wr_s    = bus.m1_write;
        end else begin
            wr_s    = 1'b0;
        end
    end

    assign bus.mem_address    = addr_s;
    assign bus.mem_byteenable = be_s;
    assign bus.mem_writedata  = wdata_s;
    assign bus.mem_chipselect = gnt_s;
    assign bus.mem_write      = wr_s;
    assign bus.m0_waitrequest = req0_s & ~gnt0_s;
    assign bus.m1_waitrequest = req1_s & ~gnt1_s;

    // FSM, round-robin pointer, held bus values and read-issue owner tag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            last_q     <= 1'b1;
            addr_q     <= {ADDR_W{1'b0}};
            be_q       <= {BE_W{1'b0}};
            wdata_q    <= {DATA_W{1'b0}};
            rd_issue_q <= 1'b0;
            rd_own_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            addr_q     <= addr_s;
            be_q       <= be_s;
            wdata_q    <= wdata_s;
            rd_issue_q <= gnt_s & ~wr_s;
            rd_own_q   <= gnt1_s;
        end
    end

    assign rdv0_s = rd_issue_q & ~rd_own_q;
    assign rdv1_s = rd_issue_q &  rd_own_q;

`ifdef MEMARB_READ_REG_EN
    logic rdv0_q, rdv1_q;

    // Extra output stage on the read return path
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdv0_q <= 1'b0;
            rdv1_q <= 1'b0;
            rd0_q  <= {DATA_W{1'b0}};
            rd1_q  <= {DATA_W{1'b0}};
        end else begin
            rdv0_q <= rdv0_s;
            rdv1_q <= rdv1_s;
            rd0_q  <= rdv0_s ? bus.mem_readdata : rd0_q;
            rd1_q  <= rdv1_s ? bus.mem_readdata : rd1_q;
        end
    end

    assign bus.m0_readdatavalid = rdv0_q;
    assign bus.m1_readdatavalid = rdv1_q;
    assign bus.m0_readdata      = rd0_q;
    assign bus.m1_readdata      = rd1_q;
`else
    logic [DATA_W-1:0] rd0_s, rd1_s;

    assign rd0_s = rdv0_s ? bus.mem_readdata : rd0_q;
    assign rd1_s = rdv1_s ? bus.mem_readdata : rd1_q;

    // Each master's readdata keeps its last returned word between pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd0_q <= {DATA_W{1'b0}};
            rd1_q <= {DATA_W{1'b0}};
        end else begin
            rd0_q <= rd0_s;
            rd1_q <= rd1_s;
        end
    end

    assign bus.m0_readdatavalid = rdv0_s;
    assign bus.m1_readdatavalid = rdv1_s;
    assign bus.m0_readdata      = rd0_s;
    assign bus.m1_readdata      = rd1_s;
`endif
endmodule

// File: tb/tb_testeio_mem_port_arbiter.sv
// Bench for testeio_mem_port_arbiter: directed scenarios plus random traffic checked
// against a transaction-level model of grants, shadow memory and read returns.
module tb_testeio_mem_port_arbiter;
    localparam int ADDR_W = 15;
    localparam int DATA_W = 32;
`ifdef MEMARB_READ_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    testeio_mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    testeio_mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    function automatic logic [31:0] init_word(input int i);
        if (i == 16)      return 32'hDEADBEEF;
        else if (i == 32) return 32'hFFFFFFFF;
        else              return 32'hC0DE0000 | 32'(i);
    endfunction

    // Memory port model: one-cycle registered read, byte-lane writes
    logic [31:0] env_mem [512];
    logic        env_init_q = 1'b0;
    logic [31:0] mem_q;
    always @(posedge clk) begin
        if (!env_init_q) begin
            for (int i = 0; i < 512; i++) env_mem[i] <= init_word(i);
            env_init_q <= 1'b1;
        end else if (bus.mem_chipselect) begin
            if (bus.mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (bus.mem_byteenable[b])
                        env_mem[bus.mem_address[8:0]][8*b +: 8] <= bus.mem_writedata[8*b +: 8];
            end else begin
                mem_q <= env_mem[bus.mem_address[8:0]];
            end
        end
    end
    assign bus.mem_readdata = mem_q;

    // Stimulus for the two requesters
    logic              dr_rd [2], dr_wr [2], dr_lk [2];
    logic [ADDR_W-1:0] dr_a  [2];
    logic [31:0]       dr_wd [2];
    logic [3:0]        dr_be [2];

    // Reference model state
    logic [31:0]       ref_mem [512];
    int                own, last, cyc;
    logic              ret_v [4];
    int                ret_o [4];
    logic [31:0]       ret_d [4];
    logic [31:0]       last_rd [2];
    logic [ADDR_W-1:0] last_addr;
    logic              acc [2];
    int                obs_rdv [2];
    int                n_checks = 0;
    int                n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %h expected %h", tag, cyc, act, exp);
        end
    endtask

    task automatic set_idle();
        for (int m = 0; m < 2; m++) begin
            dr_rd[m] = 1'b0; dr_wr[m] = 1'b0; dr_lk[m] = 1'b0;
            dr_a[m] = 15'd0; dr_wd[m] = 32'd0; dr_be[m] = 4'hF;
        end
    endtask

    task automatic apply();
        bus.m0_read = dr_rd[0]; bus.m0_write = dr_wr[0]; bus.m0_lock = dr_lk[0];
        bus.m0_address = dr_a[0]; bus.m0_writedata = dr_wd[0]; bus.m0_byteenable = dr_be[0];
        bus.m1_read = dr_rd[1]; bus.m1_write = dr_wr[1]; bus.m1_lock = dr_lk[1];
        bus.m1_address = dr_a[1]; bus.m1_writedata = dr_wd[1]; bus.m1_byteenable = dr_be[1];
    endtask

    task automatic model_reset();
        own = -1; last = 1; last_addr = 15'd0;
        last_rd[0] = 32'd0; last_rd[1] = 32'd0;
        acc[0] = 1'b0; acc[1] = 1'b0;
        for (int s = 0; s < 4; s++) ret_v[s] = 1'b0;
    endtask

    // Compare the current cycle against the rules, then commit the predicted transfer
    task automatic model_eval();
        int   g, slot;
        logic req [2];
        req[0] = dr_rd[0] | dr_wr[0];
        req[1] = dr_rd[1] | dr_wr[1];
        if (own >= 0)              g = req[own] ? own : -1;
        else if (req[0] && req[1]) g = (last == 0) ? 1 : 0;
        else if (req[0])           g = 0;
        else if (req[1])           g = 1;
        else                       g = -1;

        check_eq("m0_wait", 32'(bus.m0_waitrequest), 32'(req[0] && g != 0));
        check_eq("m1_wait", 32'(bus.m1_waitrequest), 32'(req[1] && g != 1));
        check_eq("mem_cs",  32'(bus.mem_chipselect), 32'(g >= 0));
        check_eq("mem_wr",  32'(bus.mem_write), 32'((g >= 0) ? dr_wr[g] : 1'b0));
        if (g >= 0) last_addr = dr_a[g];
        check_eq("mem_addr", 32'(bus.mem_address), 32'(last_addr));
        if (g >= 0) begin
            check_eq("mem_be", 32'(bus.mem_byteenable), 32'(dr_be[g]));
            if (dr_wr[g]) check_eq("mem_wdata", bus.mem_writedata, dr_wd[g]);
        end

        slot = cyc % 4;
        check_eq("m0_rdv", 32'(bus.m0_readdatavalid), 32'(ret_v[slot] && ret_o[slot] == 0));
        check_eq("m1_rdv", 32'(bus.m1_readdatavalid), 32'(ret_v[slot] && ret_o[slot] == 1));
        if (ret_v[slot]) last_rd[ret_o[slot]] = ret_d[slot];
        check_eq("m0_rdata", bus.m0_readdata, last_rd[0]);
        check_eq("m1_rdata", bus.m1_readdata, last_rd[1]);
        if (bus.m0_readdatavalid === 1'b1) obs_rdv[0]++;
        if (bus.m1_readdatavalid === 1'b1) obs_rdv[1]++;
        ret_v[slot] = 1'b0;

        acc[0] = 1'b0; acc[1] = 1'b0;
        if (g >= 0) begin
            acc[g] = 1'b1;
            last = g;
            if (dr_wr[g]) begin
                for (int b = 0; b < 4; b++)
                    if (dr_be[g][b]) ref_mem[dr_a[g][8:0]][8*b +: 8] = dr_wd[g][8*b +: 8];
            end else begin
                ret_v[(cyc + LAT) % 4] = 1'b1;
                ret_o[(cyc + LAT) % 4] = g;
                ret_d[(cyc + LAT) % 4] = ref_mem[dr_a[g][8:0]];
            end
            own = dr_lk[g] ? g : -1;
        end
        cyc++;
    endtask

    task automatic step();
        @(negedge clk);
        apply();
        #1;
        model_eval();
    endtask

    task automatic pick(input int m);
        int r;
        r = int'($urandom_range(0, 3));
        dr_rd[m] = (r == 1 || r == 2);
        dr_wr[m] = (r == 3);
        dr_lk[m] = ($urandom_range(0, 3) == 0);
        dr_a[m]  = 15'($urandom_range(0, 31));
        dr_wd[m] = $urandom;
        dr_be[m] = 4'($urandom_range(0, 15));
    endtask

    int na [2];

    initial begin
        cyc = 0;
        for (int i = 0; i < 512; i++) ref_mem[i] = init_word(i);
        obs_rdv[0] = 0; obs_rdv[1] = 0;
        set_idle();
        apply();
        model_reset();
        repeat (3) step();
        reset_n = 1'b1;

        // Contention from reset: both read every cycle, alternating grants starting at m0
        na[0] = 0; na[1] = 0;
        obs_rdv[0] = 0; obs_rdv[1] = 0;
        for (int k = 0; k < 8; k++) begin
            for (int m = 0; m < 2; m++) begin
                dr_rd[m] = 1'b1;
                dr_a[m]  = 15'(64 + 64 * m + na[m]);
            end
            step();
            for (int m = 0; m < 2; m++) if (acc[m]) na[m]++;
            check_eq("alt_grant_m0", 32'(acc[0]), 32'((k % 2) == 0));
        end
        set_idle();
        repeat (LAT + 1) step();
        check_eq("cont_pulses_m0", 32'(obs_rdv[0]), 32'd4);
        check_eq("cont_pulses_m1", 32'(obs_rdv[1]), 32'd4);

        // Solo read of 0x0010
        dr_rd[0] = 1'b1; dr_a[0] = 15'h0010;
        step();
        check_eq("solo_wait", 32'(bus.m0_waitrequest), 32'd0);
        set_idle();
        repeat (LAT) step();
        check_eq("solo_rdv",  32'(bus.m0_readdatavalid), 32'd1);
        check_eq("solo_data", bus.m0_readdata, 32'hDEADBEEF);
        step();

        // Lock: m1 holds the port across a locked write until its unlocking write
        dr_wr[1] = 1'b1; dr_lk[1] = 1'b1; dr_a[1] = 15'h0100; dr_wd[1] = 32'hA1B2C3D4;
        step();
        dr_wr[1] = 1'b0;
        dr_rd[0] = 1'b1; dr_a[0] = 15'h0100;
        repeat (2) begin
            step();
            check_eq("lock_m0_wait", 32'(bus.m0_waitrequest), 32'd1);
        end
        dr_wr[1] = 1'b1; dr_lk[1] = 1'b0; dr_wd[1] = 32'h55667788;
        step();
        check_eq("unlock_m0_wait", 32'(bus.m0_waitrequest), 32'd1);
        dr_wr[1] = 1'b0;
        step();
        check_eq("post_unlock_m0", 32'(bus.m0_waitrequest), 32'd0);
        set_idle();
        repeat (LAT) step();
        check_eq("lock_rdata", bus.m0_readdata, 32'h55667788);
        step();

        // Byte-lane write into an all-ones word
        dr_wr[0] = 1'b1; dr_a[0] = 15'h0020; dr_wd[0] = 32'h12345678; dr_be[0] = 4'b0101;
        step();
        set_idle();
        dr_rd[0] = 1'b1; dr_a[0] = 15'h0020;
        step();
        set_idle();
        repeat (LAT) step();
        check_eq("byte_rdata", bus.m0_readdata, 32'hFF34FF78);
        step();

        // Reset with a locked read in flight
        dr_rd[0] = 1'b1; dr_lk[0] = 1'b1; dr_a[0] = 15'h0010;
        step();
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        set_idle();
        apply();
        model_reset();
        #1;
        check_eq("rst_m0_rdv", 32'(bus.m0_readdatavalid), 32'd0);
        check_eq("rst_m0_rdata", bus.m0_readdata, 32'd0);
        check_eq("rst_cs", 32'(bus.mem_chipselect), 32'd0);
        step();
        reset_n = 1'b1;
        for (int m = 0; m < 2; m++) begin
            dr_rd[m] = 1'b1; dr_a[m] = 15'(m + 1);
        end
        step();
        check_eq("tie_after_rst_m0", 32'(bus.m0_waitrequest), 32'd0);
        check_eq("tie_after_rst_m1", 32'(bus.m1_waitrequest), 32'd1);
        step();
        set_idle();
        repeat (LAT + 1) step();

        // Random traffic; a stalled request is held until accepted
        for (int k = 0; k < 600; k++) begin
            for (int m = 0; m < 2; m++)
                if (!(dr_rd[m] | dr_wr[m]) || acc[m]) pick(m);
            step();
        end
        set_idle();
        repeat (LAT + 2) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/testeio_mem_port_arbiter.md
# testeio_mem_port_arbiter

Arbiter that shares one port of the 32K x 32 dual-port on-chip memory between two Avalon-MM requesters: the serial loader (master 0) and the genetic-circuit engine (master 1). Single-beat transfers, round-robin on contention, optional lock for atomic read-modify-write sequences. Read data is steered back to the issuing master at the memory's fixed latency.

## Interface
Parameters:
- ADDR_W, 15, word address width
- DATA_W, 32, data width; byteenable width is DATA_W/8

Ports:
- clk  in  1  sole clock; memory port runs on the same clock
- reset_n  in  1  asynchronous, active-low reset
- m0_address / m1_address  in  ADDR_W  word address
- m0_read / m1_read  in  1  read request
- m0_write / m1_write  in  1  write request
- m0_writedata / m1_writedata  in  DATA_W  write data
- m0_byteenable / m1_byteenable  in  DATA_W/8  byte lanes
- m0_lock / m1_lock  in  1  hold grant after this transfer
- m0_waitrequest / m1_waitrequest  out  1  transfer not accepted this cycle
- m0_readdata / m1_readdata  out  DATA_W  returned read data
- m0_readdatavalid / m1_readdatavalid  out  1  readdata valid strobe
- mem_address  out  ADDR_W  to memory port
- mem_byteenable  out  DATA_W/8  to memory port
- mem_chipselect  out  1  access this cycle
- mem_write  out  1  write (with chipselect)
- mem_writedata  out  DATA_W  to memory port
- mem_readdata  in  DATA_W  memory q, valid 1 cycle after read issue

## Operation
- req_i = m_i_read | m_i_write; read and write both high on one master is illegal (bench asserts).
- FSM states IDLE, OWN0, OWN1; reset -> IDLE; last-served pointer resets to 1 (master 0 wins first tie).
- IDLE: one requester -> granted; both -> the one not last served; pointer updates on every accepted transfer.
- Accepted transfer of master i with m_i_lock=1 -> OWN_i; in OWN_i only master i granted, other waits.
- OWN_i exits to IDLE after an accepted master i transfer with lock=0; lock with no request keeps OWN_i.
- Grant is combinational: winner's waitrequest=0, transfer driven to mem_* in the same cycle; m_i_waitrequest = req_i & ~grant_i.
- No grant: mem_chipselect=0, mem_write=0; mem_address/writedata hold last value.
- mem_write = grant & write; writes produce no readdatavalid.
- Read return: 1-bit owner + valid registered at issue; next cycle mem_readdata routed to owner's readdata, its readdatavalid pulsed 1 cycle. Non-owner readdata holds last value.
- Back-to-back reads (same or alternating masters) pipeline at one per cycle, no bubbles.

## Timing
- Reset values: all readdatavalid 0, all readdata 0, mem_chipselect 0, mem_write 0, mem_address 0, FSM IDLE.
- Read latency issue -> readdatavalid: 1 cycle (2 with MEMARB_READ_REG_EN).
- Write accepted the cycle waitrequest is low; data in memory at next clk edge.
- Throughput: one transfer per cycle total; under continuous contention each master gets every other cycle.
- reset_n asserted mid-lock or with a read in flight: lock dropped, pending readdatavalid discarded, immediate return to reset values.

## Configuration
- MEMARB_READ_REG_EN defined: extra output register on read path; readdata/readdatavalid one cycle later (latency 2), owner pipeline two stages deep; throughput unchanged.
- Undefined: latency 1 as above, readdata driven from the single return stage.

## Test plan
- Solo read: m0 reads addr 0x0010 (mem holds 0xDEADBEEF) -> m0_waitrequest 0 same cycle, m0_readdatavalid=1 with 0xDEADBEEF 1 cycle later (2 with macro), m1 outputs unchanged.
- Contention: m0 and m1 both read every cycle for 8 cycles from reset -> grants alternate 0,1,0,1…; each gets 4 readdatavalid pulses, data matches address.
- Lock: m1 write 0x0100 with lock=1, then m0 requests -> m0 waitrequest high until m1 issues lock=0 write to 0x0100; then m0 granted next cycle.
- Byte write: m0 writes 0x12345678 byteenable 4'b0101 to word holding 0xFFFFFFFF -> readback 0xFF34FF78.
- Reset mid-flight: assert reset_n low the cycle after an m0 read issue while in OWN0 -> no readdatavalid, FSM IDLE, first tie after release goes to m0.
